// File: rtl/ddr_rd_train_pkg.sv
// Shared types and constants for the DDR read eye-centering controller.
// Holds the FSM state enum, default parameters and training pattern bytes.
package ddr_rd_train_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CLEAR,
    ST_SAMPLE,
    ST_EVAL,
    ST_STEP,
    ST_CENTER,
    ST_DONE
  } state_e;

  // What a SETTLE period is waiting for.
  typedef enum logic [1:0] {
    PH_SWEEP,
    PH_CENTER,
    PH_PARK
  } phase_e;

  localparam int DEF_TAP_W      = 8;
  localparam int DEF_MAX_TAPS   = 128;
  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_SAMPLE_CYC = 16;
  localparam int DEF_MIN_WIN    = 4;

  localparam logic [7:0] TRAIN_PAT_A = 8'h55;
  localparam logic [7:0] TRAIN_PAT_B = 8'hAA;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr_rd_eye_centering_if.sv
// IOD-side bundle of the read eye-centering controller.
// master: controller (drives DELAY_LINE_*, CLEAR_FLAGS); slave: IOD.
interface ddr_rd_eye_centering_if;

  logic       EYE_MONITOR_EARLY;
  logic       EYE_MONITOR_LATE;
  logic       DELAY_LINE_OUT_OF_RANGE;
  logic [7:0] RX_DATA;
  logic       DELAY_LINE_LOAD;
  logic       DELAY_LINE_MOVE;
  logic       DELAY_LINE_DIRECTION;
  logic       EYE_MONITOR_CLEAR_FLAGS;

  modport master (
    input  EYE_MONITOR_EARLY,
    input  EYE_MONITOR_LATE,
    input  DELAY_LINE_OUT_OF_RANGE,
    input  RX_DATA,
    output DELAY_LINE_LOAD,
    output DELAY_LINE_MOVE,
    output DELAY_LINE_DIRECTION,
    output EYE_MONITOR_CLEAR_FLAGS
  );

  modport slave (
    output EYE_MONITOR_EARLY,
    output EYE_MONITOR_LATE,
    output DELAY_LINE_OUT_OF_RANGE,
    output RX_DATA,
    input  DELAY_LINE_LOAD,
    input  DELAY_LINE_MOVE,
    input  DELAY_LINE_DIRECTION,
    input  EYE_MONITOR_CLEAR_FLAGS
  );

endinterface

// File: rtl/rd_eye_window_track.sv
// Current/best passing-run tracker for the eye sweep.
// Ports: clr (new training), upd/pass/last/tap (per-tap verdict), best_* out.
module rd_eye_window_track #(
  parameter int TAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             upd,
  input  logic             pass,
  input  logic             last,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W-1:0] best_start,
  output logic [TAP_W:0]   best_len,
  output logic [TAP_W-1:0] best_start_nx,
  output logic [TAP_W:0]   best_len_nx
);

  logic [TAP_W-1:0] cur_start_q, cur_start_d;
  logic [TAP_W:0]   cur_len_q, cur_len_d;
  logic [TAP_W-1:0] best_start_q, best_start_d;
  logic [TAP_W:0]   best_len_q, best_len_d;
  logic [TAP_W-1:0] ext_start;
  logic [TAP_W:0]   ext_len;
  logic             close;

  always_comb begin
    ext_len   = pass ? cur_len_q + 1'b1 : cur_len_q;
    ext_start = (pass && cur_len_q == '0) ? tap : cur_start_q;
    // A run closes on a failing tap or on the final tap of the sweep.
    close     = !pass || last;

    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    if (clr) begin
      cur_start_d  = '0;
      cur_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (upd) begin
      cur_start_d = ext_start;
      cur_len_d   = close ? '0 : ext_len;
      // Strict compare: ties keep the earlier window.
      if (close && ext_len > best_len_q) begin
        best_start_d = ext_start;
        best_len_d   = ext_len;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign best_start    = best_start_q;
  assign best_len      = best_len_q;
  assign best_start_nx = best_start_d;
  assign best_len_nx   = best_len_d;

endmodule

// File: rtl/ddr_rd_eye_centering.sv
// Per-lane read eye sweep: find widest passing tap window, park at centre.
// Ports: FAB_CLK/ARST, START, iod (IOD bundle), BUSY/DONE/FAIL/WIN_*/FINAL_TAP. Option: RD_EYE_DATA_CHECK_EN.
module ddr_rd_eye_centering
  import ddr_rd_train_pkg::*;
#(
  parameter int TAP_W      = DEF_TAP_W,
  parameter int MAX_TAPS   = DEF_MAX_TAPS,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
  parameter int MIN_WIN    = DEF_MIN_WIN
) (
  input  logic                  FAB_CLK,
  input  logic                  ARST,
  input  logic                  START,
  ddr_rd_eye_centering_if.master iod,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  FAIL,
  output logic [TAP_W-1:0]      WIN_START,
  output logic [TAP_W:0]        WIN_LEN,
  output logic [TAP_W-1:0]      FINAL_TAP
);

  localparam int CNT_W = $clog2(max2(SETTLE_CYC, SAMPLE_CYC) + 1);

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             facc_q, facc_d;
  logic             oor_q, oor_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [TAP_W-1:0] wst_q, wst_d;
  logic [TAP_W:0]   wln_q, wln_d;
  logic [TAP_W-1:0] ftap_q, ftap_d;

  logic             accept;
  logic             last_settle;
  logic             last_sample;
  logic             oor_hit;
  logic             tap_pass;
  logic             sweep_end;
  logic             win_fail;
  logic             mism;
  logic [TAP_W-1:0] best_start, best_start_nx;
  logic [TAP_W:0]   best_len, best_len_nx;
  logic [TAP_W-1:0] target;

  assign accept      = START &&
                       (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_settle = cnt_q == CNT_W'(SETTLE_CYC - 1);
  assign last_sample = cnt_q == CNT_W'(SAMPLE_CYC - 1);
  assign oor_hit     = oor_q | iod.DELAY_LINE_OUT_OF_RANGE;
  assign tap_pass    = !(facc_q | oor_hit);
  assign sweep_end   = (tap_q == TAP_W'(MAX_TAPS - 1)) | oor_hit;
  assign win_fail    = best_len_nx < (TAP_W + 1)'(MIN_WIN);
  assign target      = best_start + TAP_W'(best_len >> 1);

`ifdef RD_EYE_DATA_CHECK_EN
  logic [7:0] exp_q, exp_d;

  // Phase locks on the first sample; the two patterns are bit inverses.
  always_comb begin
    mism  = 1'b0;
    exp_d = exp_q;
    if (state_q == ST_SAMPLE) begin
      if (cnt_q == '0) begin
        mism  = (iod.RX_DATA != TRAIN_PAT_A) &&
                (iod.RX_DATA != TRAIN_PAT_B);
        exp_d = (iod.RX_DATA == TRAIN_PAT_A) ? TRAIN_PAT_B
                                             : TRAIN_PAT_A;
      end else begin
        mism  = iod.RX_DATA != exp_q;
        exp_d = ~exp_q;
      end
    end
  end

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) exp_q <= '0;
    else      exp_q <= exp_d;
  end
`else
  logic unused_rx;
  assign unused_rx = ^iod.RX_DATA;
  assign mism      = 1'b0;
`endif

  rd_eye_window_track #(
    .TAP_W(TAP_W)
  ) u_track (
    .clk          (FAB_CLK),
    .rst          (ARST),
    .clr          (accept),
    .upd          (state_q == ST_EVAL),
    .pass         (tap_pass),
    .last         (sweep_end),
    .tap          (tap_q),
    .best_start   (best_start),
    .best_len     (best_len),
    .best_start_nx(best_start_nx),
    .best_len_nx  (best_len_nx)
  );

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_LOAD;
        phase_d = PH_SWEEP;
      end
      ST_LOAD:   state_d = ST_SETTLE;
      ST_SETTLE: if (last_settle) begin
        unique case (phase_q)
          PH_SWEEP:  state_d = ST_CLEAR;
          PH_CENTER: state_d = (tap_q == target) ? ST_DONE
                                                 : ST_CENTER;
          default:   state_d = ST_DONE;
        endcase
      end
      ST_CLEAR:  state_d = ST_SAMPLE;
      ST_SAMPLE: if (last_sample) state_d = ST_EVAL;
      ST_EVAL: begin
        if (!sweep_end) begin
          state_d = ST_STEP;
        end else if (win_fail) begin
          state_d = ST_LOAD;
          phase_d = PH_PARK;
        end else begin
          // One settle before centring gives DIRECTION=0 setup time.
          state_d = ST_SETTLE;
          phase_d = PH_CENTER;
        end
      end
      ST_STEP:   state_d = ST_SETTLE;
      ST_CENTER: state_d = ST_SETTLE;
      ST_DONE: begin
        state_d = accept ? ST_LOAD : ST_IDLE;
        if (accept) phase_d = PH_SWEEP;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    iod.DELAY_LINE_LOAD         = 1'b0;
    iod.DELAY_LINE_MOVE         = 1'b0;
    iod.EYE_MONITOR_CLEAR_FLAGS = 1'b0;
    unique case (state_q)
      ST_LOAD:   iod.DELAY_LINE_LOAD         = 1'b1;
      ST_STEP:   iod.DELAY_LINE_MOVE         = 1'b1;
      ST_CENTER: iod.DELAY_LINE_MOVE         = 1'b1;
      ST_CLEAR:  iod.EYE_MONITOR_CLEAR_FLAGS = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if ((state_q == ST_SETTLE && !last_settle) ||
        (state_q == ST_SAMPLE && !last_sample))
      cnt_d = cnt_q + 1'b1;

    tap_d = tap_q;
    unique case (state_q)
      ST_LOAD:   tap_d = '0;
      ST_STEP:   tap_d = tap_q + 1'b1;
      ST_CENTER: tap_d = tap_q - 1'b1;
      default: ;
    endcase

    // Out-of-range is remembered from the move until the next move.
    oor_d = oor_q | iod.DELAY_LINE_OUT_OF_RANGE;
    if (state_q == ST_LOAD || state_q == ST_STEP ||
        state_q == ST_CENTER)
      oor_d = 1'b0;

    facc_d = facc_q;
    if (state_q == ST_CLEAR)
      facc_d = 1'b0;
    else if (state_q == ST_SAMPLE)
      facc_d = facc_q | iod.EYE_MONITOR_EARLY |
               iod.EYE_MONITOR_LATE | mism;

    dir_d = dir_q;
    if (state_q == ST_LOAD && phase_q == PH_SWEEP)
      dir_d = 1'b1;
    else if (state_q == ST_EVAL && sweep_end)
      dir_d = 1'b0;

    busy_d = busy_q;
    done_d = done_q;
    fail_d = fail_q;
    wst_d  = wst_q;
    wln_d  = wln_q;
    ftap_d = ftap_q;
    if (accept) begin
      busy_d = 1'b1;
      done_d = 1'b0;
      fail_d = 1'b0;
      wst_d  = '0;
      wln_d  = '0;
      ftap_d = '0;
    end else if (state_q == ST_SETTLE && state_d == ST_DONE) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      fail_d = phase_q == PH_PARK;
      wst_d  = best_start;
      wln_d  = best_len;
      ftap_d = tap_q;
    end
  end

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      phase_q <= PH_SWEEP;
      tap_q   <= '0;
      cnt_q   <= '0;
      facc_q  <= 1'b0;
      oor_q   <= 1'b0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      wst_q   <= '0;
      wln_q   <= '0;
      ftap_q  <= '0;
    end else begin
      phase_q <= phase_d;
      tap_q   <= tap_d;
      cnt_q   <= cnt_d;
      facc_q  <= facc_d;
      oor_q   <= oor_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      wst_q   <= wst_d;
      wln_q   <= wln_d;
      ftap_q  <= ftap_d;
    end
  end

  assign iod.DELAY_LINE_DIRECTION = dir_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign FAIL      = fail_q;
  assign WIN_START = wst_q;
  assign WIN_LEN   = wln_q;
  assign FINAL_TAP = ftap_q;

endmodule

// File: tb/tb_ddr_rd_eye_centering.sv
// Directed bench for ddr_rd_eye_centering with a behavioural IOD lane.
// The IOD model tracks the tap from LOAD/MOVE and raises EARLY on failing taps.
module tb_ddr_rd_eye_centering;

  logic       FAB_CLK = 1'b0;
  logic       ARST = 1'b0;
  logic       START = 1'b0;
  logic       BUSY, DONE, FAIL;
  logic [7:0] WIN_START, FINAL_TAP;
  logic [8:0] WIN_LEN;

  int   sc = 0;
  int   tb_tap = 0;
  int   loads = 0, steps = 0, decs = 0, overlaps = 0, dir_errs = 0;
  logic dir_prev = 1'b0;
  logic rx_ph = 1'b0;
  int   checks = 0, passes = 0, fails = 0;
  int   l0, s0, d0;

  always #5 FAB_CLK = ~FAB_CLK;

  ddr_rd_eye_centering_if iod();

  ddr_rd_eye_centering dut (
    .FAB_CLK  (FAB_CLK),
    .ARST     (ARST),
    .START    (START),
    .iod      (iod),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .FAIL     (FAIL),
    .WIN_START(WIN_START),
    .WIN_LEN  (WIN_LEN),
    .FINAL_TAP(FINAL_TAP)
  );

  function automatic bit tap_pass(input int s, input int t);
    case (s)
      1, 5:    return t >= 20 && t <= 39;
      2:       return (t >= 10 && t <= 15) || (t >= 50 && t <= 69);
      3:       return (t >= 10 && t <= 19) || (t >= 40 && t <= 49);
      4:       return t >= 90;
      6:       return t >= 30 && t <= 49;
      default: return 1'b0;
    endcase
  endfunction

  assign iod.EYE_MONITOR_EARLY = (sc != 6) && !tap_pass(sc, tb_tap);
  assign iod.EYE_MONITOR_LATE  = 1'b0;
  assign iod.DELAY_LINE_OUT_OF_RANGE = (sc == 4) && (tb_tap >= 100);
  assign iod.RX_DATA = ((sc == 6) && !tap_pass(sc, tb_tap)) ? 8'h00 :
                       (rx_ph ? 8'h55 : 8'hAA);

  always @(negedge FAB_CLK) begin
    rx_ph <= ~rx_ph;
    if (int'(iod.DELAY_LINE_LOAD) + int'(iod.DELAY_LINE_MOVE) +
        int'(iod.EYE_MONITOR_CLEAR_FLAGS) > 1)
      overlaps++;
    if (iod.DELAY_LINE_LOAD) begin
      tb_tap = 0;
      loads++;
    end
    if (iod.DELAY_LINE_MOVE) begin
      if (iod.DELAY_LINE_DIRECTION !== dir_prev) dir_errs++;
      if (iod.DELAY_LINE_DIRECTION) begin
        tb_tap++;
        steps++;
      end else begin
        tb_tap--;
        decs++;
      end
    end
    dir_prev <= iod.DELAY_LINE_DIRECTION;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    l0 = loads;
    s0 = steps;
    d0 = decs;
  endtask

  task automatic pulse_start(input string tag);
    @(negedge FAB_CLK) START = 1'b1;
    @(negedge FAB_CLK) START = 1'b0;
    check({tag, " load"}, 32'(iod.DELAY_LINE_LOAD), 1);
    check({tag, " busy"}, 32'(BUSY), 1);
  endtask

  task automatic wait_tap(input string tag, input int t);
    int n = 0;
    while (tb_tap != t && n < 4000) begin
      @(negedge FAB_CLK);
      n++;
    end
    check({tag, " reach tap"}, tb_tap, t);
  endtask

  task automatic run_check(input string tag, input int f, input int ws,
                           input int wl, input int ft, input int dx,
                           input int lx);
    int n = 0;
    while (!DONE && n < 6000) begin
      @(negedge FAB_CLK);
      n++;
    end
    check({tag, " done"}, 32'(DONE), 1);
    check({tag, " busy off"}, 32'(BUSY), 0);
    check({tag, " fail"}, 32'(FAIL), f);
    check({tag, " win_start"}, 32'(WIN_START), ws);
    check({tag, " win_len"}, 32'(WIN_LEN), wl);
    check({tag, " final_tap"}, 32'(FINAL_TAP), ft);
    check({tag, " lane tap"}, tb_tap, ft);
    check({tag, " dec pulses"}, decs - d0, dx);
    check({tag, " load pulses"}, loads - l0, lx);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " load"}, 32'(iod.DELAY_LINE_LOAD), 0);
    check({tag, " move"}, 32'(iod.DELAY_LINE_MOVE), 0);
    check({tag, " dir"}, 32'(iod.DELAY_LINE_DIRECTION), 0);
    check({tag, " clr"}, 32'(iod.EYE_MONITOR_CLEAR_FLAGS), 0);
    check({tag, " busy"}, 32'(BUSY), 0);
    check({tag, " done"}, 32'(DONE), 0);
    check({tag, " fail"}, 32'(FAIL), 0);
    check({tag, " win_start"}, 32'(WIN_START), 0);
    check({tag, " win_len"}, 32'(WIN_LEN), 0);
    check({tag, " final_tap"}, 32'(FINAL_TAP), 0);
  endtask

  initial begin
    #1 ARST = 1'b1;
    repeat (3) @(negedge FAB_CLK);
    check_idle("reset");
    ARST = 1'b0;

    sc = 1;
    snap();
    pulse_start("s1");
    wait_tap("s1 mid", 10);
    @(negedge FAB_CLK) START = 1'b1;
    @(negedge FAB_CLK) START = 1'b0;
    run_check("s1", 0, 20, 20, 30, 97, 1);
    check("s1 step pulses", steps - s0, 127);

    sc = 2;
    snap();
    pulse_start("s2");
    run_check("s2", 0, 50, 20, 60, 67, 1);

    sc = 3;
    snap();
    pulse_start("tie");
    run_check("tie", 0, 10, 10, 15, 112, 1);

    sc = 0;
    snap();
    pulse_start("nopass");
    run_check("nopass", 1, 0, 0, 0, 0, 2);

    sc = 4;
    snap();
    pulse_start("oor");
    run_check("oor", 0, 90, 10, 95, 5, 1);
    check("oor step pulses", steps - s0, 100);

    sc = 5;
    pulse_start("s5");
    wait_tap("s5", 40);
    @(negedge FAB_CLK) ARST = 1'b1;
    #1;
    check("arst async load", 32'(iod.DELAY_LINE_LOAD), 0);
    check("arst async move", 32'(iod.DELAY_LINE_MOVE), 0);
    check("arst async clr", 32'(iod.EYE_MONITOR_CLEAR_FLAGS), 0);
    check("arst async busy", 32'(BUSY), 0);
    @(posedge FAB_CLK) #1;
    check_idle("arst");
    @(negedge FAB_CLK) ARST = 1'b0;
    repeat (3) @(negedge FAB_CLK);
    check("arst no move", 32'(iod.DELAY_LINE_MOVE), 0);
    snap();
    pulse_start("restart");
    run_check("restart", 0, 20, 20, 30, 97, 1);

`ifdef RD_EYE_DATA_CHECK_EN
    sc = 6;
    snap();
    pulse_start("data");
    run_check("data", 0, 30, 20, 40, 87, 1);
`endif

    check("pulse overlap", overlaps, 0);
    check("dir setup", dir_errs, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
